imsic_msi_injector: RTL
=======================

Name: imsic_msi_injector

Overview:
- Parametrised MSI traffic generator for IMSIC subsystem benches and SoC bring-up.
- Accepts (imsic, interrupt file, EIID) requests on a valid/ready port and buffers them in a FIFO.
- Converts each request into an AXI4-Lite write to the target file's setipnum_le register, with response tracking.
- Generalises the single-write master to multi-IMSIC, multi-file addressing with queueing, validation and error reporting.

Parameters:
- NR_SRC, 64, interrupt identities per file; valid EIID range is 1..NR_SRC-1.
- NR_IMSICS, 4, number of target IMSICs.
- NR_VS_FILES_PER_IMSIC, 1, number of VS files per IMSIC; NR_INTP_FILES = 2 + NR_VS_FILES_PER_IMSIC.
- AXI_ADDR_WIDTH, 64, AXI address width.
- AXI_DATA_WIDTH, 64, AXI data width; must be 32 or 64.
- FIFO_DEPTH, 4, request queue depth; must be a power of two and at least 2.
- BASE_ADDR, 64'h2400_0000, address of IMSIC 0, M file.
- IMSIC_STRIDE, 32'h8000, address stride between IMSICs; elaboration error if less than NR_INTP_FILES*0x1000.
- MAX_RETRY, 2, maximum reissues per request (used only with IMSIC_INJ_RETRY_EN).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request ready
- i_req_imsic  in  $clog2(NR_IMSICS)+1  target IMSIC index
- i_req_file  in  $clog2(NR_INTP_FILES)+1  file index: 0=M, 1=S, 2+k=VS file k
- i_req_eiid  in  $clog2(NR_SRC)+1  interrupt identity
- o_awvalid  out  1  AXI write address valid
- i_awready  in  1  AXI write address ready
- o_awaddr  out  AXI_ADDR_WIDTH  AXI write address
- o_wvalid  out  1  AXI write data valid
- i_wready  in  1  AXI write data ready
- o_wdata  out  AXI_DATA_WIDTH  AXI write data
- o_wstrb  out  AXI_DATA_WIDTH/8  AXI write strobes
- i_bvalid  in  1  AXI write response valid
- o_bready  out  1  AXI write response ready
- i_bresp  in  2  AXI write response code
- o_drop  out  1  one-cycle pulse: request rejected by validation
- o_err  out  1  one-cycle pulse: request abandoned after a non-OKAY response
- o_busy  out  1  FIFO non-empty or transaction in flight
- o_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: all outputs 0 except o_req_ready=1. FIFO emptied, FSM to IDLE.
  - Reset mid-transaction abandons the write: awvalid, wvalid and bready drop at the reset edge, and no o_err is raised.
- Handshake: o_req_ready = !full. A request is accepted when valid && ready.
  - Push is blocked when full, even if a pop occurs in the same cycle.
- Validation at acceptance: reject if imsic>=NR_IMSICS, file>=NR_INTP_FILES, eiid==0 or eiid>=NR_SRC.
  - A rejected request is still handshaken (ready honoured), is not queued, and pulses o_drop in the next cycle.
- Address: BASE_ADDR + imsic*IMSIC_STRIDE + file*0x1000, computed at push time in AXI_ADDR_WIDTH arithmetic.
- Data: o_wdata = eiid zero-extended; o_wstrb = 4'hF in the low lane, 0 elsewhere.
- FSM:
  - IDLE: if FIFO non-empty, pop the head and go to ADDR_DATA. o_awvalid and o_wvalid both rise the next cycle.
  - ADDR_DATA: hold awvalid until awready and wvalid until wready; each channel drops independently on its handshake. When both are done, go to RESP.
  - RESP: o_bready=1. On bvalid:
    - OKAY (2'b00): go to IDLE.
    - Otherwise: pulse o_err and go to IDLE.
- Latency: a request accepted in cycle N into an idle, empty injector presents AW/W in cycle N+2 (push at edge N, pop at edge N+1).
- Throughput: with zero-wait slaves, one write per 3 cycles (IDLE, ADDR_DATA, RESP).
- Ordering: strict FIFO order, one outstanding transaction.
- Push and pop in the same cycle: o_level is unchanged; the pointers wrap modulo FIFO_DEPTH.
- o_busy = (o_level!=0) || FSM!=IDLE.

Optional Feature:
- Macro: IMSIC_INJ_RETRY_EN.
- When defined: a non-OKAY bresp returns the FSM to ADDR_DATA with the same address and data and increments a per-request retry counter.
  - o_err pulses only when a non-OKAY response arrives after MAX_RETRY reissues.
  - The retry counter resets on each new pop.
- When undefined: no retry, no counter; the first non-OKAY response pulses o_err.

Test Plan:
- Reset, then push (imsic=1, file=0, eiid=5) with an always-ready slave -> one AW at 0x2400_8000, wdata=5, wstrb=0x0F, o_err=0, o_busy low 3 cycles after the AW handshake.
- Push 6 requests back-to-back with FIFO_DEPTH=4 and awready held low -> o_req_ready drops once o_level=4; after release, 6 writes are issued in push order.
- Push eiid=0, then file=3 with NR_VS_FILES_PER_IMSIC=1, then imsic=4 -> three o_drop pulses, no AXI traffic, o_level stays 0.
- wready asserted 3 cycles before awready -> wvalid drops after its handshake while awvalid stays high; exactly one B accepted.
- bresp=SLVERR on every response -> without the macro, 1 write and 1 o_err; with the macro, 3 writes, then o_err.
- Assert i_rst during RESP with 2 queued requests -> next cycle all valids are 0, o_level=0, no o_err; a new push proceeds normally.

Source files
------------

// File: rtl/imsic_msi_injector.sv
// Queues (imsic, file, eiid) requests and issues each as one AXI4-Lite write to setipnum_le.
// Latency: request accepted at edge N is popped at edge N+1, so AW/W are valid from edge N+1.
// Backpressure: o_req_ready = !full; one write outstanding; IMSIC_INJ_RETRY_EN enables reissue on error.
module imsic_msi_injector #(
    parameter int          NR_SRC                = 64,
    parameter int          NR_IMSICS             = 4,
    parameter int          NR_VS_FILES_PER_IMSIC = 1,
    parameter int          AXI_ADDR_WIDTH        = 64,
    parameter int          AXI_DATA_WIDTH        = 64,
    parameter int          FIFO_DEPTH            = 4,
    parameter logic [63:0] BASE_ADDR             = 64'h2400_0000,
    parameter logic [31:0] IMSIC_STRIDE          = 32'h8000,
    parameter int          MAX_RETRY             = 2,
    localparam int         NR_INTP_FILES         = 2 + NR_VS_FILES_PER_IMSIC,
    localparam int         IW                    = $clog2(NR_IMSICS) + 1,
    localparam int         FW                    = $clog2(NR_INTP_FILES) + 1,
    localparam int         EW                    = $clog2(NR_SRC) + 1,
    localparam int         LW                    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_req_valid,
    output logic                        o_req_ready,
    input  logic [IW-1:0]               i_req_imsic,
    input  logic [FW-1:0]               i_req_file,
    input  logic [EW-1:0]               i_req_eiid,
    output logic                        o_awvalid,
    input  logic                        i_awready,
    output logic [AXI_ADDR_WIDTH-1:0]   o_awaddr,
    output logic                        o_wvalid,
    input  logic                        i_wready,
    output logic [AXI_DATA_WIDTH-1:0]   o_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] o_wstrb,
    input  logic                        i_bvalid,
    output logic                        o_bready,
    input  logic [1:0]                  i_bresp,
    output logic                        o_drop,
    output logic                        o_err,
    output logic                        o_busy,
    output logic [LW-1:0]               o_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = AXI_DATA_WIDTH / 8;

    if (!(AXI_DATA_WIDTH == 32 || AXI_DATA_WIDTH == 64)) begin : g_chk_dw
        $error("AXI_DATA_WIDTH must be 32 or 64");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (IMSIC_STRIDE < NR_INTP_FILES * 32'h1000) begin : g_chk_stride
        $error("IMSIC_STRIDE smaller than the interrupt-file window");
    end
    if (MAX_RETRY < 0) begin : g_chk_retry
        $error("MAX_RETRY must be non-negative");
    end

    typedef struct packed {
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [EW-1:0]             eiid;
    } entry_t;

    typedef enum logic [1:0] {IDLE, ADDR_DATA, RESP} state_t;

    entry_t        mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] count;
    state_t        state;
    entry_t        head;
    entry_t        push_entry;
    logic          req_ok;
    logic          accept;
    logic          push;
    logic          pop;

    assign req_ok = (i_req_imsic < IW'(NR_IMSICS)) && (i_req_file < FW'(NR_INTP_FILES)) &&
                    (i_req_eiid != '0) && (i_req_eiid < EW'(NR_SRC));
    assign accept = i_req_valid && o_req_ready;
    assign push   = accept && req_ok;
    assign pop    = (state == IDLE) && (count != '0);
    assign head   = mem[rd_ptr];

    // Target address is resolved once at push time so the FIFO carries a ready-to-issue write.
    assign push_entry.addr = AXI_ADDR_WIDTH'(BASE_ADDR)
                           + AXI_ADDR_WIDTH'(i_req_imsic) * AXI_ADDR_WIDTH'(IMSIC_STRIDE)
                           + AXI_ADDR_WIDTH'(i_req_file) * AXI_ADDR_WIDTH'(32'h1000);
    assign push_entry.eiid = i_req_eiid;

    assign o_req_ready = (count != LW'(FIFO_DEPTH));
    assign o_level     = count;
    assign o_busy      = (count != '0) || (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + LW'(push) - LW'(pop);
        end
    end

`ifdef IMSIC_INJ_RETRY_EN
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RW-1:0] retry_cnt;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            o_awvalid <= 1'b0;
            o_wvalid  <= 1'b0;
            o_bready  <= 1'b0;
            o_awaddr  <= '0;
            o_wdata   <= '0;
            o_wstrb   <= '0;
            o_drop    <= 1'b0;
            o_err     <= 1'b0;
`ifdef IMSIC_INJ_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            o_drop <= accept && !req_ok;
            o_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        o_awaddr  <= head.addr;
                        o_wdata   <= AXI_DATA_WIDTH'(head.eiid);
                        o_wstrb   <= SW'(4'hF);
                        o_awvalid <= 1'b1;
                        o_wvalid  <= 1'b1;
                        state     <= ADDR_DATA;
`ifdef IMSIC_INJ_RETRY_EN
                        retry_cnt <= '0;
`endif
                    end
                end
                ADDR_DATA: begin
                    if (i_awready) begin
                        o_awvalid <= 1'b0;
                    end
                    if (i_wready) begin
                        o_wvalid <= 1'b0;
                    end
                    if ((!o_awvalid || i_awready) && (!o_wvalid || i_wready)) begin
                        o_bready <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (i_bvalid) begin
                        o_bready <= 1'b0;
                        state    <= IDLE;
                        if (i_bresp != 2'b00) begin
`ifdef IMSIC_INJ_RETRY_EN
                            if (retry_cnt < RW'(MAX_RETRY)) begin
                                retry_cnt <= retry_cnt + RW'(1);
                                o_awvalid <= 1'b1;
                                o_wvalid  <= 1'b1;
                                state     <= ADDR_DATA;
                            end else begin
                                o_err <= 1'b1;
                            end
`else
                            o_err <= 1'b1;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
